// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer.
// Next-state select encodings, also used by the control-word ROM.
package useq_pkg;

  typedef enum logic [2:0] {
    NS_DIR  = 3'b000,
    NS_IB   = 3'b001,
    NS_SB   = 3'b010,
    NS_CBIT = 3'b011,
    NS_CJMP = 3'b100,
    NS_CALL = 3'b101,
    NS_RET  = 3'b110,
    NS_SEQ  = 3'b111
  } ns_e;

endpackage

// File: rtl/micro_ret_stack.sv
// Micro-return LIFO: push/pop with top-of-stack, occupancy, full/empty.
// Ports: clk, rst (sync, pointer only), push, pop, din -> top, sp, full, empty.
module micro_ret_stack #(
  parameter int SW    = 5,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [SW-1:0] din,
  output logic [SW-1:0] top,
  output logic [PW-1:0] sp,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SW-1:0] mem [DEPTH];
  logic [PW-1:0] cnt;
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == PW'(DEPTH));
  assign empty   = (cnt == '0);
  assign widx    = AW'(cnt);
  assign ridx    = AW'(cnt - PW'(1));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top     = empty ? '0 : mem[ridx];
  assign sp      = cnt;

  // Entries are never cleared; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[widx] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (do_push) cnt <= cnt + PW'(1);
    else if (do_pop)  cnt <= cnt - PW'(1);
  end

endmodule

// File: rtl/micro_sequencer.sv
// Registered microprogram sequencer with conditions and call/return.
// Ports: clk, rst, ibin, sbin, dbin, cond, csel, nssel, stall -> state, sp, stk_ovf, stk_unf.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int SW       = 5,
  parameter int NCOND    = 4,
  parameter int DEPTH    = 4,
  parameter int RESET_ST = 0,
  localparam int CSW     = $clog2(NCOND),
  localparam int PW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW-1:0]    ibin,
  input  logic [SW-1:0]    sbin,
  input  logic [SW-1:0]    dbin,
  input  logic [NCOND-1:0] cond,
  input  logic [CSW-1:0]   csel,
  input  logic [2:0]       nssel,
  input  logic             stall,
  output logic [SW-1:0]    state,
  output logic [PW-1:0]    sp,
  output logic             stk_ovf,
  output logic             stk_unf
);

  localparam logic [SW-1:0] RST_ST = SW'(RESET_ST);

  // Zero-padded so out-of-range selects read as 0.
  logic [(2**CSW)-1:0] condx;
  logic                c;
  logic [SW-1:0]       inc;
  logic [SW-1:0]       nxt;
  logic [SW-1:0]       top;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                ovf_set;
  logic                unf_set;

  assign condx = (2**CSW)'(cond);
  assign c     = condx[csel];
  assign inc   = state + SW'(1);

  always_comb begin
    nxt     = state;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (ns_e'(nssel))
      NS_DIR:  nxt = dbin;
      NS_IB:   nxt = ibin;
      NS_SB:   nxt = sbin;
      NS_CBIT: nxt = {dbin[SW-1:1], c};
      NS_CJMP: nxt = c ? dbin : inc;
      NS_CALL: begin
        nxt     = dbin;
        push    = !stall;
        ovf_set = full;
      end
      NS_RET: begin
        nxt     = empty ? RST_ST : top;
        pop     = !stall;
        unf_set = empty;
      end
      NS_SEQ:  nxt = inc;
    endcase
  end

  micro_ret_stack #(
    .SW    (SW),
    .DEPTH (DEPTH)
  ) u_stk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .top   (top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RST_ST;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (!stall) begin
      state   <= nxt;
      stk_ovf <= stk_ovf | ovf_set;
      stk_unf <= stk_unf | unf_set;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer.
// Queue-based stack model compared every cycle, plus literal checkpoints.
module tb_micro_sequencer;

  localparam int SW    = 5;
  localparam int NCOND = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   ibin = 5'd12;
  logic [4:0]   sbin = 5'd17;
  logic [4:0]   dbin = 5'd7;
  logic [3:0]   cond = '0;
  logic [1:0]   csel = '0;
  logic [2:0]   nssel = 3'b000;
  logic         stall = 1'b0;
  logic [4:0]   state;
  logic [2:0]   sp;
  logic         stk_ovf;
  logic         stk_unf;

  int n_checks = 0;
  int n_fail   = 0;

  int m_state = 0;
  int m_stk[$];
  bit m_ovf = 0;
  bit m_unf = 0;
  bit valid = 0;

  micro_sequencer #(
    .SW       (SW),
    .NCOND    (NCOND),
    .DEPTH    (DEPTH),
    .RESET_ST (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ibin    (ibin),
    .sbin    (sbin),
    .dbin    (dbin),
    .cond    (cond),
    .csel    (csel),
    .nssel   (nssel),
    .stall   (stall),
    .state   (state),
    .sp      (sp),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: next state from the select rules, stack as a queue.
  always @(posedge clk) begin
    int c;
    int inc;
    int d;
    if (rst) begin
      m_state = 0;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
      valid = 1;
    end else if (!stall) begin
      c   = (int'(csel) < NCOND) ? int'(cond[csel]) : 0;
      inc = (m_state + 1) % 32;
      d   = int'(dbin);
      case (nssel)
        3'd0: m_state = d;
        3'd1: m_state = int'(ibin);
        3'd2: m_state = int'(sbin);
        3'd3: m_state = (d / 2) * 2 + c;
        3'd4: m_state = c ? d : inc;
        3'd5: begin
          if (m_stk.size() == DEPTH) m_ovf = 1;
          else m_stk.push_back(inc);
          m_state = d;
        end
        3'd6: begin
          if (m_stk.size() == 0) begin
            m_state = 0;
            m_unf = 1;
          end else begin
            m_state = m_stk.pop_back();
          end
        end
        default: m_state = inc;
      endcase
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      check("m_state", int'(state), m_state);
      check("m_sp", int'(sp), m_stk.size());
      check("m_ovf", int'(stk_ovf), int'(m_ovf));
      check("m_unf", int'(stk_unf), int'(m_unf));
    end
  end

  task automatic go(input logic r, input logic s, input logic [2:0] ns,
                    input logic [4:0] d, input logic [3:0] cd,
                    input logic [1:0] cs);
    rst   = r;
    stall = s;
    nssel = ns;
    dbin  = d;
    cond  = cd;
    csel  = cs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    go(1, 0, 3'd0, 5'd7, 4'h0, 2'd0);
    check("rst_state", int'(state), 0);
    check("rst_sp", int'(sp), 0);
    check("rst_flags", int'({stk_ovf, stk_unf}), 0);

    go(0, 0, 3'd3, 5'b10110, 4'b0001, 2'd0);
    check("cbit_c1", int'(state), 23);
    go(0, 0, 3'd3, 5'b10110, 4'b1110, 2'd0);
    check("cbit_c0", int'(state), 22);
    go(0, 0, 3'd3, 5'b01000, 4'b0100, 2'd2);
    check("cbit_sel2", int'(state), 9);

    go(0, 0, 3'd0, 5'd31, 4'h0, 2'd0);
    go(0, 0, 3'd7, 5'd0, 4'h0, 2'd0);
    check("seq_wrap", int'(state), 0);
    go(0, 0, 3'd4, 5'd9, 4'b1110, 2'd0);
    check("cjmp_c0", int'(state), 1);
    go(0, 0, 3'd4, 5'd9, 4'b0001, 2'd0);
    check("cjmp_c1", int'(state), 9);
    go(0, 0, 3'd1, 5'd0, 4'h0, 2'd0);
    check("ib", int'(state), 12);
    go(0, 0, 3'd2, 5'd0, 4'h0, 2'd0);
    check("sb", int'(state), 17);

    go(0, 0, 3'd0, 5'd3, 4'h0, 2'd0);
    go(0, 0, 3'd5, 5'd10, 4'h0, 2'd0);
    check("call1", int'({state, sp}), (10 << 3) | 1);
    go(0, 0, 3'd5, 5'd20, 4'h0, 2'd0);
    check("call2", int'({state, sp}), (20 << 3) | 2);
    go(0, 0, 3'd6, 5'd0, 4'h0, 2'd0);
    check("ret1", int'({state, sp}), (11 << 3) | 1);
    go(0, 0, 3'd6, 5'd0, 4'h0, 2'd0);
    check("ret2", int'({state, sp}), (4 << 3) | 0);

    go(0, 0, 3'd6, 5'd9, 4'h0, 2'd0);
    check("unf_state", int'(state), 0);
    check("unf_flag", int'(stk_unf), 1);

    for (int i = 1; i <= DEPTH + 1; i++) go(0, 0, 3'd5, 5'(i), 4'h0, 2'd0);
    check("ovf_state", int'(state), 5);
    check("ovf_sp", int'(sp), DEPTH);
    check("ovf_flag", int'(stk_ovf), 1);
    go(0, 0, 3'd6, 5'd0, 4'h0, 2'd0);
    check("ret_after_ovf", int'(state), 4);

    go(1, 1, 3'd5, 5'd8, 4'h0, 2'd0);
    check("rst_over_stall", int'({state, sp, stk_ovf, stk_unf}), 0);
    go(0, 0, 3'd0, 5'd0, 4'h0, 2'd0);
    for (int i = 0; i < 3; i++) go(0, 1, 3'd5, 5'd8, 4'h0, 2'd0);
    check("stall_hold", int'({state, sp}), 0);
    go(0, 0, 3'd5, 5'd8, 4'h0, 2'd0);
    check("stall_release", int'({state, sp}), (8 << 3) | 1);
    go(0, 0, 3'd7, 5'd0, 4'h0, 2'd0);
    go(0, 0, 3'd6, 5'd0, 4'h0, 2'd0);
    check("stall_once", int'({state, sp}), (1 << 3) | 0);
    check("stall_noflag", int'({stk_ovf, stk_unf}), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
